// File: rtl/serial_word_deframer.sv
// serial_word_deframer
//
// Purpose:
//   Hunts a 1-bit serial stream for a SYNC word. It then captures the next
//   MSB bits, MSB-first, as one payload word and pushes that word into a
//   small first-word-fall-through FIFO. The FIFO is offered on a
//   valid/ready interface. Every frame is SYNC followed by exactly one
//   payload word, after which the block goes back to hunting.
//
// Ports:
//   clk        in   1    single clock, all state updates on the rising edge
//   reset      in   1    synchronous active-high reset, clears all state
//   data_in    in   1    serial bit, sampled on every rising edge
//   out_data   out  MSB  FIFO head word (0 while the FIFO is empty)
//   out_valid  out  1    FIFO is non-empty
//   out_ready  in   1    head is consumed when out_valid && out_ready at an edge
//   locked     out  1    high while payload bits are being captured
//   overflow   out  1    sticky; a completed word was dropped on a full FIFO

module serial_word_deframer #(
  parameter int             MSB   = 8,
  parameter logic [MSB-1:0] SYNC  = 8'hA5,
  parameter int             DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           data_in,
  output logic [MSB-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           locked,
  output logic           overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(MSB);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t state_q, state_d;

  // The window and payload registers keep only MSB-1 bits. The newest bit
  // comes straight from data_in, so a full MSB-bit word is available at the
  // very edge that samples its last bit.
  logic [MSB-2:0]   window_q;
  logic [MSB-2:0]   pay_q;
  logic [BIT_W-1:0] hunt_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;

  logic [MSB-1:0]   sample;
  logic [MSB-1:0]   word;
  logic             sync_hit;
  logic             word_done;

  logic [MSB-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             push;
  logic             pop;
  logic             accept;

  // Framing decisions. A sync match needs MSB fresh bits since entering HUNT.
  // hunt_cnt saturating at MSB-1 means MSB-1 bits are already in the window
  // and the current bit is the MSB-th.
  always_comb begin
    state_d   = state_q;
    sample    = {window_q, data_in};
    word      = {pay_q, data_in};
    sync_hit  = 1'b0;
    word_done = 1'b0;

    case (state_q)
      HUNT: begin
        if (sample == SYNC && hunt_cnt_q == BIT_W'(MSB - 1)) begin
          sync_hit = 1'b1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (bit_cnt_q == BIT_W'(MSB - 1)) begin
          word_done = 1'b1;
          state_d   = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Serial datapath. Payload bits never enter the sync window, and the window
  // is cleared when a word completes. A payload equal to SYNC therefore
  // cannot retrigger framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_q   <= '0;
      pay_q      <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        HUNT: begin
          window_q <= sample[MSB-2:0];
          if (hunt_cnt_q != BIT_W'(MSB - 1)) begin
            hunt_cnt_q <= hunt_cnt_q + 1'b1;
          end
          if (sync_hit) begin
            bit_cnt_q <= '0;
          end
        end
        PAYLOAD: begin
          pay_q     <= word[MSB-2:0];
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (word_done) begin
            window_q   <= '0;
            hunt_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end
        default: begin
          window_q   <= '0;
          hunt_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign locked = (state_q == PAYLOAD);

  // FIFO handshake. A pop at the same edge frees a slot, so a push onto a
  // full FIFO is still accepted when the head is consumed at that edge.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = word_done;
  assign pop       = out_valid && out_ready;
  assign accept    = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

  // Storage has no reset. Entries are only visible through out_data while
  // count says they hold data.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wr_ptr_q] <= word;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The count
  // register resolves the full/empty ambiguity of equal pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_deframer.sv
// tb_serial_word_deframer
//
// Purpose:
//   Self-checking bench for serial_word_deframer. A frame-level model runs on
//   every clock. It tracks the bit history since hunting began, the collected
//   payload bits and a queue of delivered words. A compare process checks all
//   outputs against that model one time unit after each rising edge. Directed
//   scenarios add literal expectations that pin the model itself.
//
// Ports: none (top-level bench).

module tb_serial_word_deframer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       locked;
  logic       overflow;

  int vectors = 0;
  int failures = 0;

  serial_word_deframer #(
    .MSB   (8),
    .SYNC  (SYNC),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: hist holds bits seen since hunting began (last 8 kept),
  // pay holds the payload bits collected so far, fifo_q holds delivered words.
  bit         hunting = 1'b1;
  bit         hist[$];
  bit         pay[$];
  logic [7:0] fifo_q[$];
  bit         ovf = 1'b0;

  always @(posedge clk) begin : model_and_compare
    bit         do_pop;
    bit         do_push;
    logic [7:0] new_word;
    int         v;

    if (reset) begin
      hunting = 1'b1;
      hist.delete();
      pay.delete();
      fifo_q.delete();
      ovf = 1'b0;
    end else begin
      do_pop   = (fifo_q.size() != 0) && out_ready;
      do_push  = 1'b0;
      new_word = '0;
      if (hunting) begin
        hist.push_back(data_in);
        if (hist.size() > 8) void'(hist.pop_front());
        if (hist.size() == 8) begin
          v = 0;
          foreach (hist[i]) v = v * 2 + int'(hist[i]);
          if (v == int'(SYNC)) begin
            hunting = 1'b0;
            pay.delete();
          end
        end
      end else begin
        pay.push_back(data_in);
        if (pay.size() == 8) begin
          v = 0;
          foreach (pay[i]) v = v * 2 + int'(pay[i]);
          new_word = v[7:0];
          do_push  = 1'b1;
          hunting  = 1'b1;
          hist.delete();
        end
      end
      if (do_push && fifo_q.size() == DEPTH && !do_pop) begin
        ovf = 1'b1;
        if (do_pop) void'(fifo_q.pop_front());
      end else begin
        if (do_pop) void'(fifo_q.pop_front());
        if (do_push) fifo_q.push_back(new_word);
      end
    end

    #1;
    checkOutput("cyc_out_valid", out_valid, fifo_q.size() != 0);
    checkOutput("cyc_out_data", out_data, (fifo_q.size() != 0) ? fifo_q[0] : 8'h00);
    checkOutput("cyc_locked", locked, !hunting);
    checkOutput("cyc_overflow", overflow, ovf);
  end

  // One clock of stimulus: inputs change on the falling edge, and the task
  // returns just after the following rising edge and its cycle compare.
  task automatic applyStimulus(input logic r, input logic d, input logic rdy);
    @(negedge clk);
    reset     = r;
    data_in   = d;
    out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic rdy_body, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, b[i], (i == 0) ? rdy_last : rdy_body);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    // 1. Reset while data_in toggles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i[0], 1'b1);
      checkOutput("rst_valid", out_valid, 1'b0);
      checkOutput("rst_locked", locked, 1'b0);
      checkOutput("rst_overflow", overflow, 1'b0);
      checkOutput("rst_data", out_data, 8'h00);
    end

    // 2. A5 then 3C with consumer always ready.
    sendByte(SYNC, 1'b1, 1'b1);
    checkOutput("t2_locked_after_sync", locked, 1'b1);
    sendByte(8'h3C, 1'b1, 1'b1);
    checkOutput("t2_locked_after_word", locked, 1'b0);
    checkOutput("t2_valid", out_valid, 1'b1);
    checkOutput("t2_data", out_data, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t2_popped", out_valid, 1'b0);

    // 3. A payload equal to SYNC is plain data.
    doReset();
    sendByte(8'hA5, 1'b0, 1'b0);
    sendByte(8'hA5, 1'b0, 1'b0);
    sendByte(8'hA5, 1'b0, 1'b0);
    sendByte(8'h5A, 1'b0, 1'b0);
    checkOutput("t3_first", out_data, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_second", out_data, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_empty", out_valid, 1'b0);

    // 4. Five frames with no consumer: fifth word dropped, overflow sticks.
    doReset();
    for (int f = 1; f <= 5; f++) begin
      sendByte(SYNC, 1'b0, 1'b0);
      sendByte(8'(f), 1'b0, 1'b0);
    end
    checkOutput("t4_overflow", overflow, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("t4_drain_valid", out_valid, 1'b1);
      checkOutput("t4_drain_data", out_data, 32'(k));
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("t4_drained", out_valid, 1'b0);
    checkOutput("t4_overflow_sticky", overflow, 1'b1);

    // 5. Full FIFO, pop coincides with the fifth word's last-bit edge.
    doReset();
    for (int f = 1; f <= 4; f++) begin
      sendByte(SYNC, 1'b0, 1'b0);
      sendByte(8'(f), 1'b0, 1'b0);
    end
    sendByte(SYNC, 1'b0, 1'b0);
    sendByte(8'h05, 1'b0, 1'b1);
    checkOutput("t5_overflow", overflow, 1'b0);
    checkOutput("t5_head", out_data, 8'h02);
    for (int k = 2; k <= 5; k++) begin
      checkOutput("t5_drain_data", out_data, 32'(k));
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("t5_drained", out_valid, 1'b0);

    // 6. Reset mid-payload discards the partial word; framing restarts.
    doReset();
    sendByte(SYNC, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_reset_locked", locked, 1'b0);
    sendByte(8'h3C, 1'b0, 1'b0);
    checkOutput("t6_no_word", out_valid, 1'b0);
    checkOutput("t6_not_locked", locked, 1'b0);
    sendByte(SYNC, 1'b0, 1'b0);
    sendByte(8'h3C, 1'b0, 1'b0);
    checkOutput("t6_valid", out_valid, 1'b1);
    checkOutput("t6_data", out_data, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
